bcd_encoder_seq: RTL and testbench
==================================

# bcd_encoder_seq

Parametrised sequential binary-to-BCD converter using shift-add-3 (double dabble), one input bit per clock. It is the generalised successor to the fixed 32-bit/8-digit encoder. Binary width and digit count are parameters, and it adds a start/busy/done handshake, a decimal overflow flag and a leading-zero blanking mask. It sits between the arithmetic datapath and the seven-segment/display formatting logic.

## Interface
Parameters:
- `BIN_W`, default 32, width of the binary input.
- `DIGITS`, default 10, number of BCD digits produced.

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a conversion. Sampled only in IDLE.
- `binary`, input, `BIN_W`: value to convert. Sampled on the edge that accepts `start`.
- `length`, input, 8: number of significant low bits of `binary` to convert. Sampled with `start`.
- `bcd`, output, 4*`DIGITS`: result. Digit i occupies bits [4i+3:4i], with digit 0 least significant. Registered.
- `blank`, output, `DIGITS`: bit i set means digit i is a leading zero. Registered.
- `overflow`, output, 1: the value did not fit in `DIGITS` digits. Registered, valid with `done`.
- `busy`, output, 1: conversion in progress.
- `done`, output, 1: single-cycle pulse when a new `bcd` is valid.

## Operation
- States: IDLE and SHIFT.
- IDLE:
  - When `start`=1, compute the effective length L = min(`length`, `BIN_W`).
  - Load the shift register with `binary` << (`BIN_W`-L), so the converted bits are MSB-aligned. Clear the digit register and the sticky overflow. Set the bit counter to L.
  - If L>0, go to SHIFT. If L=0, load `bcd`=0, `overflow`=0 and `blank` (see below), pulse `done`, and stay in IDLE.
- SHIFT, every cycle:
  - (1) Add 3 to each digit whose value is ≥5.
  - (2) Shift {digits, shift register} left by one. The shift-register MSB enters digit 0 bit 0.
  - (3) If the bit shifted out of digit `DIGITS`-1 is 1, set sticky overflow.
  - Decrement the counter.
  - On the shift where the counter reaches 0: load `bcd` with the post-shift digits, `overflow` with the sticky flag including this shift, and `blank` from the new digits. Pulse `done` and return to IDLE.
- Overflow result: `bcd` holds value mod 10^`DIGITS`.
- `blank[i]` = 1 iff digits i..`DIGITS`-1 are all zero, with i ≥ 1. `blank[0]` is always 0.
- `start` in SHIFT is ignored. It is not queued.
- `bcd`, `blank` and `overflow` hold their values until the next `done`.
- Inputs `binary` and `length` may change freely after the accepting edge.

## Timing
- Reset (asynchronous, any state including mid-SHIFT): state=IDLE, `bcd`=0, `blank`=0, `overflow`=0, `busy`=0, `done`=0. The internal registers are cleared and any conversion in flight is discarded with no `done`.
- Edge E0 accepts `start`. Edges E1..EL perform the L shifts. `done`=1 for exactly the cycle after EL, so latency is L cycles from the accepting edge.
- With L=0, `done`=1 in the cycle after E0.
- `busy`=1 from after E0 through the cycle before `done`. It is 0 in the `done` cycle.
- `start` asserted in the `done` cycle is accepted, giving back-to-back conversions every L+1 cycles.
- No combinational path from inputs to outputs.

## Test plan
- Defaults, `binary`=162, `length`=8:
  - `done` 8 cycles after the accepting edge.
  - `bcd`=0x0000000162.
  - `blank`=10'b1111111000, `overflow`=0.
  - `busy` high for cycles 1–7.
- `binary`=12345678, `length`=24 → `bcd`=0x0012345678 after 24 cycles. Then `binary`=0xFFFFFFFF, `length`=40 (clamped to 32) → `bcd`=0x4294967295 after 32 cycles, `overflow`=0, `blank`=0.
- `DIGITS`=4, `BIN_W`=16, `binary`=12345, `length`=14 → `bcd`=0x2345, `overflow`=1. A following conversion of 99 → `overflow`=0.
- `length`=0 with `binary`=0xFFFF → `done` the next cycle, `bcd`=0, `blank`=all digits except 0.
- `reset` pulsed at cycle 5 of a 24-bit conversion → all outputs 0 immediately and no `done` is produced. A fresh `start` then converts correctly.
- `start` held high throughout → conversions repeat every L+1 cycles. A different `binary` presented while `busy` does not affect the current result.

Source files
------------

// File: rtl/bcd_encoder_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock,
// with start/busy/done handshake, decimal overflow flag and leading-zero mask.
module bcd_encoder_seq #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      binary,
    input  logic [7:0]            length,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic [BIN_W-1:0]       sr_q, sr_d;
    logic [DIGITS-1:0][3:0] dig_q, dig_d;
    logic [DIGITS-1:0][3:0] adj, shifted;
    logic [CW-1:0]          cnt_q, cnt_d, eff_len;
    logic                   sticky_q, sticky_d;
    logic [DIGITS-1:0][3:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]      blank_q, blank_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;
    logic                   carry_out;
    logic [31:0]            shamt;

    // blank[i] set when digits i..top are all zero; digit 0 is never blanked.
    function automatic logic [DIGITS-1:0] lead_zero(input logic [DIGITS-1:0][3:0] d);
        logic all_zero;
        all_zero  = 1'b1;
        lead_zero = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero     = all_zero & (d[i] == 4'd0);
            lead_zero[i] = all_zero;
        end
    endfunction

    always_comb begin
        if (32'(length) >= 32'(BIN_W)) eff_len = CW'(BIN_W);
        else                           eff_len = CW'(length);
        shamt = 32'(BIN_W) - 32'(eff_len);
    end

    // Add-3 correction then one-bit shift of {digits, shift register}.
    always_comb begin
        for (int i = 0; i < DIGITS; i++)
            adj[i] = (dig_q[i] >= 4'd5) ? dig_q[i] + 4'd3 : dig_q[i];
        shifted[0] = {adj[0][2:0], sr_q[BIN_W-1]};
        for (int i = 1; i < DIGITS; i++)
            shifted[i] = {adj[i][2:0], adj[i-1][3]};
        carry_out = adj[DIGITS-1][3];
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        dig_d    = dig_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        blank_d  = blank_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d     = binary << shamt;
                    dig_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = eff_len;
                    if (eff_len == '0) begin
                        bcd_d   = '0;
                        ovf_d   = 1'b0;
                        blank_d = lead_zero('0);
                        done_d  = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sr_d     = sr_q << 1;
                dig_d    = shifted;
                sticky_d = sticky_q | carry_out;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shifted;
                    ovf_d   = sticky_q | carry_out;
                    blank_d = lead_zero(shifted);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            dig_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            blank_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            dig_q    <= dig_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            blank_q  <= blank_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign bcd      = bcd_q;
    assign blank    = blank_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == SHIFT);
    assign done     = done_q;

endmodule

// File: tb/tb_bcd_encoder_seq.sv
// Scoreboard bench for bcd_encoder_seq: a default 32b/10-digit instance and a
// 16b/4-digit instance, checked against a divide-by-ten reference model.
module tb_bcd_encoder_seq;

    typedef struct {
        logic [39:0] bcd;
        logic [9:0]  blank;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk, reset, start, start2;
    logic [31:0] binary;
    logic [7:0]  length;
    logic [39:0] bcd1;
    logic [9:0]  blank1;
    logic        ovf1, busy1, done1;
    logic [15:0] bcd2;
    logic [3:0]  blank2;
    logic        ovf2, busy2, done2;

    int   ecnt = 0;
    int   nvec = 0;
    int   nfail = 0;
    int   b1_lo = 0, b1_hi = 0, b2_lo = 0, b2_hi = 0;
    exp_t q1[$];
    exp_t q2[$];

    bcd_encoder_seq u_dut1 (
        .clk(clk), .reset(reset), .start(start), .binary(binary), .length(length),
        .bcd(bcd1), .blank(blank1), .overflow(ovf1), .busy(busy1), .done(done1)
    );

    bcd_encoder_seq #(.BIN_W(16), .DIGITS(4)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .binary(binary[15:0]), .length(length),
        .bcd(bcd2), .blank(blank2), .overflow(ovf2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic exp_t model(input logic [31:0] bin, input int len, input int binw,
                                   input int digits, input int due_base);
        longint unsigned v, pw, r;
        int   l;
        bit   allz;
        exp_t e;
        l  = (len > binw) ? binw : len;
        v  = (l == 0) ? 64'd0 : (64'(bin) & ((64'd1 << l) - 64'd1));
        pw = 1;
        for (int i = 0; i < digits; i++) pw = pw * 10;
        e.ovf   = (v >= pw);
        e.bcd   = '0;
        e.blank = '0;
        r = v;
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        allz = 1'b1;
        for (int i = digits - 1; i >= 1; i--) begin
            allz = allz & (e.bcd[4*i +: 4] == 4'd0);
            e.blank[i] = allz;
        end
        e.due = due_base + l;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, got, exp, ecnt);
        end
    endtask

    task automatic flag(input string name);
        nvec++;
        nfail++;
        $display("FAIL %s (edge %0d)", name, ecnt);
    endtask

    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            chk("busy1", 64'(busy1), 64'(ecnt >= b1_lo && ecnt < b1_hi));
            if (done1) begin
                if (q1.size() == 0) flag("done1 unexpected");
                else begin
                    e = q1.pop_front();
                    chk("done1 latency", 64'(ecnt), 64'(e.due));
                    chk("bcd1", 64'(bcd1), 64'(e.bcd));
                    chk("blank1", 64'(blank1), 64'(e.blank));
                    chk("ovf1", 64'(ovf1), 64'(e.ovf));
                end
            end else if (q1.size() > 0 && ecnt >= q1[0].due) begin
                flag("done1 missing");
                void'(q1.pop_front());
            end
        end
    end

    initial begin : mon2
        exp_t e;
        forever begin
            @(negedge clk);
            chk("busy2", 64'(busy2), 64'(ecnt >= b2_lo && ecnt < b2_hi));
            if (done2) begin
                if (q2.size() == 0) flag("done2 unexpected");
                else begin
                    e = q2.pop_front();
                    chk("done2 latency", 64'(ecnt), 64'(e.due));
                    chk("bcd2", 64'(bcd2), 64'(e.bcd));
                    chk("blank2", 64'(blank2), 64'(e.blank));
                    chk("ovf2", 64'(ovf2), 64'(e.ovf));
                end
            end else if (q2.size() > 0 && ecnt >= q2[0].due) begin
                flag("done2 missing");
                void'(q2.pop_front());
            end
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle of the
    // 32-bit instance, where the next start can be accepted.
    task automatic run(input logic [31:0] b, input int len, input bit hold);
        int l1, l2, k;
        l1 = (len > 32) ? 32 : len;
        l2 = (len > 16) ? 16 : len;
        k  = ecnt;
        start  = 1'b1;
        start2 = 1'b1;
        binary = b;
        length = 8'(len);
        q1.push_back(model(b, len, 32, 10, k + 1));
        q2.push_back(model({16'b0, b[15:0]}, len, 16, 4, k + 1));
        b1_lo = k + 1; b1_hi = k + 1 + l1;
        b2_lo = k + 1; b2_hi = k + 1 + l2;
        for (int i = 0; i <= l1; i++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            start2 = 1'b0;
            binary = $urandom;
            length = 8'($urandom);
        end
    endtask

    task automatic idle(input int n);
        start  = 1'b0;
        start2 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " bcd1"}, 64'(bcd1), 64'd0);
        chk({tag, " blank1"}, 64'(blank1), 64'd0);
        chk({tag, " ovf1"}, 64'(ovf1), 64'd0);
        chk({tag, " busy1"}, 64'(busy1), 64'd0);
        chk({tag, " done1"}, 64'(done1), 64'd0);
        chk({tag, " bcd2"}, 64'(bcd2), 64'd0);
        chk({tag, " blank2"}, 64'(blank2), 64'd0);
        chk({tag, " ovf2"}, 64'(ovf2), 64'd0);
    endtask

    initial begin
        int k;
        reset  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        binary = '0;
        length = '0;
        #1 reset = 1'b1;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run(32'd162, 8, 1'b0);
        idle(2);
        run(32'd12345678, 24, 1'b0);
        run(32'hFFFF_FFFF, 40, 1'b0);
        run(32'd12345, 14, 1'b0);
        run(32'd99, 8, 1'b0);
        run(32'h0000_FFFF, 0, 1'b0);
        idle(1);

        // Abort a 24-bit conversion mid-flight with an asynchronous reset.
        k = ecnt;
        start  = 1'b1;
        binary = 32'd9876543;
        length = 8'd24;
        b1_lo = k + 1; b1_hi = k + 25;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        q1.delete();
        q2.delete();
        b1_lo = 0; b1_hi = 0; b2_lo = 0; b2_hi = 0;
        #1 chk_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        run(32'd12345678, 24, 1'b0);

        // start held high: back-to-back conversions, inputs scrambled while busy.
        for (int i = 0; i < 6; i++) run($urandom, int'($urandom_range(0, 33)), 1'b1);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            run($urandom, (i % 4 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 32)), 1'b0);
            if (i % 3 == 0) idle(i % 5);
        end
        idle(5);

        if (q1.size() != 0) flag("queue1 not drained");
        if (q2.size() != 0) flag("queue2 not drained");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
